// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding an 8N1 UART serialiser.
// Accepts one-cycle push strobes, never stalls the producer, and flags dropped bytes.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic [7:0] sdata,
  output logic       txd,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0]         CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [CW-1:0]         baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;

  logic has_data;
  logic bit_end;
  logic push;
  logic pop;

  assign has_data = (count != '0);
  assign full     = (count == COUNT_FULL);
  assign bit_end  = (baud_cnt == CNT_LAST);
  assign push     = tx_ready & ~full;
  // The head is popped the moment a frame starts, so its slot frees immediately.
  assign pop      = has_data & ((state == IDLE) | ((state == STOP) & bit_end));
  assign busy     = (state != IDLE) | has_data;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (tx_ready & full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (has_data) begin
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more bytes wait.
            if (has_data) begin
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
